// File: rtl/sram_host_ctrl.sv
// Host command sequencer for sram_top: serialises write words MSB first, then load/w_en; reads wait on data_valid.
// Latency: write COLS+2 cycles accept-to-idle; read 1..TIMEOUT cycles in READ, then RESP until taken.
// Backpressure: req_ready only in IDLE; RESP holds rsp_rdata/rsp_err stable until rsp_ready.
module sram_host_ctrl #(
    parameter int ROWS    = 8,
    parameter int COLS    = 8,
    parameter int ADDR_W  = $clog2(ROWS),
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [COLS-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [COLS-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              serial_in,
    output logic              shift,
    output logic              load,
    output logic              w_en,
    output logic              r_en,
    output logic [ADDR_W-1:0] addr,
    input  logic              data_valid,
    input  logic [COLS-1:0]   data_out,
    output logic              busy
);

    localparam int BCNT_W = $clog2(COLS) + 1;
    localparam int TCNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(COLS);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, SHIFT, LOAD, WRITE, READ, RESP
    } state_t;

    state_t              state_q, state_d;
    logic [COLS-1:0]     data_q, data_d;
    logic [ADDR_W-1:0]   addr_lat_q, addr_lat_d;
    logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [TCNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic                req_ready_q, req_ready_d;
    logic                busy_q, busy_d;
    logic                shift_q, shift_d;
    logic                load_q, load_d;
    logic                w_en_q, w_en_d;
    logic                r_en_q, r_en_d;
    logic                serial_in_q, serial_in_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [COLS-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        addr_lat_d  = addr_lat_q;
        bit_cnt_d   = bit_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        serial_in_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_lat_d = req_addr;
                    if (req_wr) begin
                        // First bit goes out on the same edge the word is latched.
                        state_d     = SHIFT;
                        data_d      = req_wdata;
                        serial_in_d = req_wdata[COLS-1];
                        bit_cnt_d   = BCNT_W'(1);
                    end else begin
                        state_d   = READ;
                        tmo_cnt_d = '0;
                    end
                end
            end
            SHIFT: begin
                if (bit_cnt_q == BCNT_LAST) begin
                    state_d = LOAD;
                end else begin
                    data_d      = {data_q[COLS-2:0], 1'b0};
                    serial_in_d = data_q[COLS-2];
                    bit_cnt_d   = bit_cnt_q + BCNT_W'(1);
                end
            end
            LOAD:  state_d = WRITE;
            WRITE: begin
                state_d = IDLE;
                data_d  = '0;
            end
            READ: begin
                // data_valid is checked first so it wins on the final timeout cycle.
                if (data_valid) begin
                    state_d     = RESP;
                    rsp_rdata_d = data_out;
                    rsp_err_d   = 1'b0;
                end else if (tmo_cnt_q == TCNT_LAST) begin
                    state_d     = RESP;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TCNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered copies of the next-state decode.
        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        shift_d     = (state_d == SHIFT);
        load_d      = (state_d == LOAD);
        w_en_d      = (state_d == WRITE);
        r_en_d      = (state_d == READ);
        rsp_valid_d = (state_d == RESP);
        addr_d      = (state_d == IDLE) ? '0 : addr_lat_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            addr_lat_q  <= '0;
            bit_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            shift_q     <= 1'b0;
            load_q      <= 1'b0;
            w_en_q      <= 1'b0;
            r_en_q      <= 1'b0;
            serial_in_q <= 1'b0;
            addr_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            addr_lat_q  <= addr_lat_d;
            bit_cnt_q   <= bit_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            shift_q     <= shift_d;
            load_q      <= load_d;
            w_en_q      <= w_en_d;
            r_en_q      <= r_en_d;
            serial_in_q <= serial_in_d;
            addr_q      <= addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign shift     = shift_q;
    assign load      = load_q;
    assign w_en      = w_en_q;
    assign r_en      = r_en_q;
    assign serial_in = serial_in_q;
    assign addr      = addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_sram_host_ctrl.sv
// Bench for sram_host_ctrl: per-transaction expected output traces checked every cycle, plus literal spot checks.
module tb_sram_host_ctrl;

    localparam int ROWS    = 8;
    localparam int COLS    = 8;
    localparam int ADDR_W  = 3;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [COLS-1:0]   req_wdata;
    logic              rsp_valid, rsp_ready;
    logic [COLS-1:0]   rsp_rdata;
    logic              rsp_err;
    logic              serial_in, shift, load, w_en, r_en;
    logic [ADDR_W-1:0] addr;
    logic              data_valid;
    logic [COLS-1:0]   data_out;
    logic              busy;

    always #5 clk = ~clk;

    sram_host_ctrl #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .serial_in(serial_in), .shift(shift), .load(load), .w_en(w_en), .r_en(r_en),
        .addr(addr), .data_valid(data_valid), .data_out(data_out), .busy(busy)
    );

    typedef struct packed {
        logic              req_ready;
        logic              busy;
        logic              shift;
        logic              load;
        logic              w_en;
        logic              r_en;
        logic              serial_in;
        logic [ADDR_W-1:0] addr;
        logic              rsp_valid;
        logic [COLS-1:0]   rsp_rdata;
        logic              rsp_err;
    } obs_t;

    obs_t            exp_q[$];
    obs_t            last_obs;
    int              checks = 0;
    int              failures = 0;
    int              cyc = 0;
    int              n_shift = 0, n_load = 0, n_wen = 0, n_ren = 0, n_rspv = 0;
    int              last_acc = 0, prev_acc = 0;
    logic [COLS-1:0] ser_cap = '0;
    logic [COLS-1:0] last_rdata = '0;
    logic            last_err = 1'b0;
    logic [ADDR_W-1:0] wen_addr = '0;
    logic [COLS-1:0] mem [ROWS];

    function automatic obs_t idle_obs();
        obs_t o;
        o = '0;
        o.req_ready = 1'b1;
        return o;
    endfunction

    // Cycle k (1-based) after a write is accepted: COLS shift cycles MSB first, one load, one w_en.
    function automatic obs_t wr_obs(input logic [ADDR_W-1:0] a, input logic [COLS-1:0] d, input int k);
        obs_t o;
        logic [COLS-1:0] t;
        o = '0;
        o.busy = 1'b1;
        o.addr = a;
        t = d << (k - 1);
        if (k <= COLS) begin
            o.shift     = 1'b1;
            o.serial_in = t[COLS-1];
        end else if (k == COLS + 1) begin
            o.load = 1'b1;
        end else begin
            o.w_en = 1'b1;
        end
        return o;
    endfunction

    function automatic obs_t rd_obs(input logic [ADDR_W-1:0] a, input bit resp,
                                    input logic [COLS-1:0] rd, input logic er);
        obs_t o;
        o = '0;
        o.busy = 1'b1;
        o.addr = a;
        if (!resp) begin
            o.r_en = 1'b1;
        end else begin
            o.rsp_valid = 1'b1;
            o.rsp_rdata = rd;
            o.rsp_err   = er;
        end
        return o;
    endfunction

    task automatic check_cycle();
        obs_t got, exp;
        got = {req_ready, busy, shift, load, w_en, r_en, serial_in, addr, rsp_valid, rsp_rdata, rsp_err};
        last_obs = got;
        cyc++;
        if (shift) begin
            n_shift++;
            ser_cap = {ser_cap[COLS-2:0], serial_in};
        end
        if (load) n_load++;
        if (w_en) begin
            n_wen++;
            wen_addr = addr;
        end
        if (r_en) n_ren++;
        if (rsp_valid) begin
            n_rspv++;
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
        end
        if (req_valid && req_ready) begin
            prev_acc = last_acc;
            last_acc = cyc;
        end
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        else                  exp = idle_obs();
        if (!exp.shift) begin
            got.serial_in = 1'b0;
            exp.serial_in = 1'b0;
        end
        if (!exp.rsp_valid) begin
            got.rsp_rdata = '0;
            got.rsp_err   = 1'b0;
            exp.rsp_rdata = '0;
            exp.rsp_err   = 1'b0;
        end
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL cycle_outputs cyc=%0d got=%05h exp=%05h", cyc, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [COLS-1:0] d);
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        step();
        req_valid = 1'b0;
        req_wdata = COLS'($urandom);
        for (int k = 1; k <= COLS + 2; k++) exp_q.push_back(wr_obs(a, d, k));
        mem[a] = d;
        repeat (COLS + 2) step();
    endtask

    // dv_k: READ cycle on which data_valid is offered (0 = never); rdy_k: RESP cycles held off.
    task automatic do_read(input logic [ADDR_W-1:0] a, input int dv_k, input int rdy_k, input bit noise);
        int              n_rd;
        bit              tmo;
        logic [COLS-1:0] rd;
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = a;
        req_wdata = COLS'($urandom);
        step();
        req_valid = 1'b0;
        tmo  = !(dv_k >= 1 && dv_k <= TIMEOUT);
        n_rd = tmo ? TIMEOUT : dv_k;
        rd   = tmo ? '0 : mem[a];
        for (int k = 0; k < n_rd; k++) exp_q.push_back(rd_obs(a, 1'b0, '0, 1'b0));
        for (int k = 0; k <= rdy_k; k++) exp_q.push_back(rd_obs(a, 1'b1, rd, tmo));
        for (int k = 1; k <= n_rd; k++) begin
            data_valid = (k == dv_k);
            data_out   = (k == dv_k) ? mem[a] : COLS'($urandom);
            step();
        end
        data_valid = 1'b0;
        for (int k = 0; k <= rdy_k; k++) begin
            rsp_ready  = (k == rdy_k);
            data_valid = noise;
            data_out   = COLS'($urandom);
            step();
        end
        rsp_ready  = 1'b0;
        data_valid = 1'b0;
    endtask

    int s_shift, s_load, s_wen, s_ren, s_rspv;

    task automatic snap();
        s_shift = n_shift;
        s_load  = n_load;
        s_wen   = n_wen;
        s_ren   = n_ren;
        s_rspv  = n_rspv;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; data_valid = 1'b0; data_out = '0;
        for (int i = 0; i < ROWS; i++) mem[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        step();
        check_lit("reset_state", 32'(last_obs), 32'(idle_obs()));
        rst = 1'b0;
        step();

        // Reset during the 4th shift cycle aborts the write.
        snap();
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 3'd3; req_wdata = 8'hA5;
        step();
        req_valid = 1'b0;
        for (int k = 1; k <= 4; k++) exp_q.push_back(wr_obs(3'd3, 8'hA5, k));
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_lit("rst_mid_shift_ready", 32'(last_obs.req_ready), 32'd0);
        step();
        check_lit("rst_after_ready", 32'(last_obs.req_ready), 32'd1);
        repeat (12) step();
        check_lit("rst_shift_cycles", n_shift - s_shift, 4);
        check_lit("rst_no_load", n_load - s_load, 0);
        check_lit("rst_no_wen", n_wen - s_wen, 0);

        snap();
        do_write(3'd2, 8'hA5);
        check_lit("wr_serial_word", 32'(ser_cap), 32'h0000_00A5);
        check_lit("wr_shift_cycles", n_shift - s_shift, 8);
        check_lit("wr_load_cycles", n_load - s_load, 1);
        check_lit("wr_wen_cycles", n_wen - s_wen, 1);
        check_lit("wr_wen_addr", 32'(wen_addr), 32'd2);

        do_write(3'd5, 8'h3C);
        check_lit("accept_spacing", last_acc - prev_acc, 11);

        snap();
        do_read(3'd5, 3, 0, 1'b0);
        check_lit("rd_ren_cycles", n_ren - s_ren, 3);
        check_lit("rd_rdata", 32'(last_rdata), 32'h3C);
        check_lit("rd_err", 32'(last_err), 32'd0);
        check_lit("rd_rsp_cycles", n_rspv - s_rspv, 1);

        snap();
        do_read(3'd1, 0, 0, 1'b0);
        check_lit("tmo_ren_cycles", n_ren - s_ren, 16);
        check_lit("tmo_err", 32'(last_err), 32'd1);
        check_lit("tmo_rdata", 32'(last_rdata), 32'd0);

        snap();
        do_read(3'd5, TIMEOUT, 1, 1'b0);
        check_lit("edge_ren_cycles", n_ren - s_ren, 16);
        check_lit("edge_err", 32'(last_err), 32'd0);
        check_lit("edge_rdata", 32'(last_rdata), 32'h3C);

        do_write(3'd6, 8'hFF);
        snap();
        do_read(3'd6, 2, 5, 1'b1);
        check_lit("bp_rsp_cycles", n_rspv - s_rspv, 6);
        check_lit("bp_rdata", 32'(last_rdata), 32'hFF);

        for (int i = 0; i < ROWS; i++) do_write(ADDR_W'(i), COLS'(~i));
        for (int i = 0; i < ROWS; i++) do_read(ADDR_W'(i), (i % 4) + 1, i % 3, i[0]);
        check_lit("sweep_last_rdata", 32'(last_rdata), 32'hF8);

        repeat (4) step();
        check_lit("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
